// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decode stage: ALU op codes, main-control
// oper classes, R-type funct values and the sequencer state encoding.
package alu_ctrl_pkg;

  // Mul/div countdown width; covers cycle counts up to 64.
  localparam int CNT_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11,
    ALU_LUI  = 4'd12,
    ALU_MUL  = 4'd13,
    ALU_DIV  = 4'd14
  } alu_op_e;

  // Main-control oper classes
  localparam logic [3:0] OPER_LDST   = 4'b0000;
  localparam logic [3:0] OPER_BRANCH = 4'b0001;
  localparam logic [3:0] OPER_RTYPE  = 4'b0010;
  localparam logic [3:0] OPER_ADDI   = 4'b1000;
  localparam logic [3:0] OPER_ADDIU  = 4'b1001;
  localparam logic [3:0] OPER_SLTI   = 4'b1010;
  localparam logic [3:0] OPER_SLTIU  = 4'b1011;
  localparam logic [3:0] OPER_ANDI   = 4'b1100;
  localparam logic [3:0] OPER_ORI    = 4'b1101;
  localparam logic [3:0] OPER_XORI   = 4'b1110;
  localparam logic [3:0] OPER_LUI    = 4'b1111;

  // R-type funct values
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational oper/funct decoder producing the ALU op and side flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPER_W = 4
) (
  input  logic [OPER_W-1:0] oper,
  input  logic [5:0]        funct,
  output alu_op_e           alu_op,
  output logic              shamt_sel,
  output logic              is_unsigned,
  output logic              is_md,
  output logic              illegal
);

  // Decode class code first, then the funct field for R-type.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    alu_op      = ALU_ADD;
    shamt_sel   = 1'b0;
    is_unsigned = 1'b0;
    is_md       = 1'b0;
    illegal     = 1'b0;
    case (oper)
      OPER_W'(OPER_LDST),
      OPER_W'(OPER_ADDI):   alu_op = ALU_ADD;
      OPER_W'(OPER_BRANCH): alu_op = ALU_SUB;
      OPER_W'(OPER_ADDIU):  is_unsigned = 1'b1;
      OPER_W'(OPER_SLTI):   alu_op = ALU_SLT;
      OPER_W'(OPER_SLTIU): begin
        alu_op      = ALU_SLTU;
        is_unsigned = 1'b1;
      end
      OPER_W'(OPER_ANDI):   alu_op = ALU_AND;
      OPER_W'(OPER_ORI):    alu_op = ALU_OR;
      OPER_W'(OPER_XORI):   alu_op = ALU_XOR;
      OPER_W'(OPER_LUI):    alu_op = ALU_LUI;
      OPER_W'(OPER_RTYPE): begin
        case (funct)
          FN_ADD:   alu_op = ALU_ADD;
          FN_ADDU:  is_unsigned = 1'b1;
          FN_SUB:   alu_op = ALU_SUB;
          FN_SUBU: begin
            alu_op      = ALU_SUB;
            is_unsigned = 1'b1;
          end
          FN_AND:   alu_op = ALU_AND;
          FN_OR:    alu_op = ALU_OR;
          FN_XOR:   alu_op = ALU_XOR;
          FN_NOR:   alu_op = ALU_NOR;
          FN_SLT:   alu_op = ALU_SLT;
          FN_SLTU: begin
            alu_op      = ALU_SLTU;
            is_unsigned = 1'b1;
          end
          FN_SLL: begin
            alu_op    = ALU_SLL;
            shamt_sel = 1'b1;
          end
          FN_SRL: begin
            alu_op    = ALU_SRL;
            shamt_sel = 1'b1;
          end
          FN_SRA: begin
            alu_op    = ALU_SRA;
            shamt_sel = 1'b1;
          end
          FN_SLLV:  alu_op = ALU_SLL;
          FN_SRLV:  alu_op = ALU_SRL;
          FN_SRAV:  alu_op = ALU_SRA;
          FN_MULT, FN_MULTU: begin
            alu_op      = ALU_MUL;
            is_md       = 1'b1;
            is_unsigned = (funct == FN_MULTU);
          end
          FN_DIV, FN_DIVU: begin
            alu_op      = ALU_DIV;
            is_md       = 1'b1;
            is_unsigned = (funct == FN_DIVU);
          end
          default:  illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ID/EX decode stage with valid/ready handshake and a countdown
// sequencer that holds the stage while a multi-cycle mul/div runs.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPER_W     = 4,
  parameter int ALU_OP_W   = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPER_W-1:0]   oper,
  input  logic [5:0]          funct,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                shamt_sel,
  output logic                is_unsigned,
  output logic                md_start,
  output logic                md_busy,
  output logic                illegal
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  alu_op_e    dec_alu_op;
  logic       dec_shamt_sel, dec_is_unsigned, dec_is_md, dec_illegal;

  state_e     state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       shamt_sel_q, shamt_sel_d;
  logic       is_unsigned_q, is_unsigned_d;
  logic       illegal_q, illegal_d;
  logic       md_start_q, md_start_d;
  logic       md_busy_q, md_busy_d;
  // Keeps in_ready low while reset is held and for the first cycle after release.
  logic       ready_en_q, ready_en_d;
  logic       accept;

  alu_ctrl_decode #(.OPER_W(OPER_W)) u_decode (
    .oper        (oper),
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .shamt_sel   (dec_shamt_sel),
    .is_unsigned (dec_is_unsigned),
    .is_md       (dec_is_md),
    .illegal     (dec_illegal)
  );

  assign in_ready = ready_en_q && (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Next-state and output-register logic for the handshake and mul/div sequencer.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    out_valid_d   = out_valid_q;
    alu_op_d      = alu_op_q;
    shamt_sel_d   = shamt_sel_q;
    is_unsigned_d = is_unsigned_q;
    illegal_d     = illegal_q;
    md_start_d    = 1'b0;
    md_busy_d     = md_busy_q;
    ready_en_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op_d      = dec_alu_op;
          shamt_sel_d   = dec_shamt_sel;
          is_unsigned_d = dec_is_unsigned;
          illegal_d     = dec_illegal;
          if (dec_is_md) begin
            state_d     = MD_RUN;
            md_start_d  = 1'b1;
            md_busy_d   = 1'b1;
            out_valid_d = 1'b0;
            counter_d   = (dec_alu_op == ALU_MUL) ? MUL_LOAD : DIV_LOAD;
          end else begin
            out_valid_d = 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      MD_RUN: begin
        if (counter_q == '0) begin
          out_valid_d = 1'b1;
          md_busy_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      md_busy_d   = 1'b0;
      md_start_d  = 1'b0;
      counter_d   = '0;
      state_d     = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      out_valid_q   <= 1'b0;
      alu_op_q      <= 4'd0;
      shamt_sel_q   <= 1'b0;
      is_unsigned_q <= 1'b0;
      illegal_q     <= 1'b0;
      md_start_q    <= 1'b0;
      md_busy_q     <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      counter_q     <= counter_d;
      out_valid_q   <= out_valid_d;
      alu_op_q      <= alu_op_d;
      shamt_sel_q   <= shamt_sel_d;
      is_unsigned_q <= is_unsigned_d;
      illegal_q     <= illegal_d;
      md_start_q    <= md_start_d;
      md_busy_q     <= md_busy_d;
      ready_en_q    <= ready_en_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_op      = ALU_OP_W'(alu_op_q);
  assign shamt_sel   = shamt_sel_q;
  assign is_unsigned = is_unsigned_q;
  assign illegal     = illegal_q;
  assign md_start    = md_start_q;
  assign md_busy     = md_busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode tables, backpressure, mul/div timing,
// flush and reset. Instance a uses default cycle counts, instance b MUL_CYCLES=1.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] oper = 4'd0;
  logic [5:0] funct = 6'd0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_shamt_sel, a_is_unsigned, a_md_start, a_md_busy, a_illegal;
  logic [3:0] a_alu_op;
  logic       b_in_ready, b_out_valid, b_shamt_sel, b_is_unsigned, b_md_start, b_md_busy, b_illegal;
  logic [3:0] b_alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .oper(oper), .funct(funct), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .alu_op(a_alu_op), .shamt_sel(a_shamt_sel),
    .is_unsigned(a_is_unsigned), .md_start(a_md_start), .md_busy(a_md_busy),
    .illegal(a_illegal)
  );

  alu_ctrl_seq #(.MUL_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .oper(oper), .funct(funct), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .alu_op(b_alu_op), .shamt_sel(b_shamt_sel),
    .is_unsigned(b_is_unsigned), .md_start(b_md_start), .md_busy(b_md_busy),
    .illegal(b_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {md_busy, md_start, out_valid, alu_op[3:0], shamt_sel, is_unsigned, illegal}
  function automatic logic [31:0] view_a();
    return {22'd0, a_md_busy, a_md_start, a_out_valid, a_alu_op, a_shamt_sel, a_is_unsigned, a_illegal};
  endfunction

  function automatic logic [31:0] view_b();
    return {22'd0, b_md_busy, b_md_start, b_out_valid, b_alu_op, b_shamt_sel, b_is_unsigned, b_illegal};
  endfunction

  // Hand-built expected view: valid output with the given fields, no mul/div activity.
  function automatic logic [31:0] exp_out(input logic [3:0] op, input logic s, input logic u, input logic i);
    return {22'd0, 3'b001, op, s, u, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // R-type table: funct, expected {alu_op, shamt_sel, is_unsigned, illegal}
  logic [5:0] r_funct [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                               6'h3f, 6'h01};
  logic [6:0] r_exp [18] = '{{4'd0, 3'b000}, {4'd0, 3'b010}, {4'd1, 3'b000}, {4'd1, 3'b010},
                             {4'd4, 3'b000}, {4'd2, 3'b000}, {4'd6, 3'b000}, {4'd3, 3'b000},
                             {4'd10, 3'b000}, {4'd11, 3'b010}, {4'd7, 3'b100}, {4'd8, 3'b100},
                             {4'd9, 3'b100}, {4'd7, 3'b000}, {4'd8, 3'b000}, {4'd9, 3'b000},
                             {4'd0, 3'b001}, {4'd0, 3'b001}};
  // I-type table: oper, expected {alu_op, shamt_sel, is_unsigned, illegal}
  logic [3:0] i_oper [12] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                              4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0011, 4'b0111};
  logic [6:0] i_exp [12] = '{{4'd0, 3'b000}, {4'd1, 3'b000}, {4'd0, 3'b000}, {4'd0, 3'b010},
                             {4'd10, 3'b000}, {4'd11, 3'b010}, {4'd4, 3'b000}, {4'd2, 3'b000},
                             {4'd6, 3'b000}, {4'd12, 3'b000}, {4'd0, 3'b001}, {4'd0, 3'b001}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("reset_view_a", view_a(), 32'd0);
    check("reset_ready_a", {31'd0, a_in_ready}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("release_ready_a", {31'd0, a_in_ready}, 32'd1);
    check("release_valid_a", {31'd0, a_out_valid}, 32'd0);

    // R-type sweep, back-to-back accepts
    out_ready = 1'b1;
    in_valid  = 1'b1;
    oper      = 4'b0010;
    for (int i = 0; i < 18; i++) begin
      funct = r_funct[i];
      step();
      check($sformatf("rtype_%02h", r_funct[i]), view_a(),
            exp_out(r_exp[i][6:3], r_exp[i][2], r_exp[i][1], r_exp[i][0]));
    end

    // I-type sweep; funct set to MULT to prove it is ignored outside R-type
    funct = 6'h18;
    for (int i = 0; i < 12; i++) begin
      oper = i_oper[i];
      step();
      check($sformatf("itype_%04b", i_oper[i]), view_a(),
            exp_out(i_exp[i][6:3], i_exp[i][2], i_exp[i][1], i_exp[i][0]));
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, a_out_valid}, 32'd0);

    // Backpressure: ORI accepted, then held three cycles while XORI waits
    oper = 4'b1101; in_valid = 1'b1; out_ready = 1'b0;
    step();
    check("bp_accept", view_a(), exp_out(4'd2, 1'b0, 1'b0, 1'b0));
    oper = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_ready_%0d", k), {31'd0, a_in_ready}, 32'd0);
      step();
      check($sformatf("bp_hold_%0d", k), view_a(), exp_out(4'd2, 1'b0, 1'b0, 1'b0));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
    step();
    check("bp_next", view_a(), exp_out(4'd6, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    step();
    check("bp_drain", {31'd0, a_out_valid}, 32'd0);

    // DIVU, 32 cycles, with a LUI request stalled behind it
    oper = 4'b0010; funct = 6'h1b; in_valid = 1'b1;
    step();
    oper = 4'b1111;
    check("divu_start", {28'd0, a_md_busy, a_md_start, a_out_valid, a_in_ready}, 32'b1100);
    for (int k = 1; k < 32; k++) begin
      step();
      check($sformatf("divu_busy_%0d", k), {28'd0, a_md_busy, a_md_start, a_out_valid, a_in_ready}, 32'b1000);
    end
    step();
    check("divu_done", view_a(), exp_out(4'd14, 1'b0, 1'b1, 1'b0));
    step();
    check("divu_follow_lui", view_a(), exp_out(4'd12, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    step();

    // MULTU: instance b (1 cycle) and instance a (4 cycles)
    oper = 4'b0010; funct = 6'h19; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mul1_start_b", {29'd0, b_md_busy, b_md_start, b_out_valid}, 32'b110);
    check("mul4_start_a", {29'd0, a_md_busy, a_md_start, a_out_valid}, 32'b110);
    step();
    check("mul1_done_b", view_b(), exp_out(4'd13, 1'b0, 1'b1, 1'b0));
    check("mul4_busy_a", {29'd0, a_md_busy, a_md_start, a_out_valid}, 32'b100);
    step();
    step();
    check("mul4_busy_a_e3", {29'd0, a_md_busy, a_md_start, a_out_valid}, 32'b100);
    step();
    check("mul4_done_a", view_a(), exp_out(4'd13, 1'b0, 1'b1, 1'b0));
    step();

    // Flush while counter is at 10
    oper = 4'b0010; funct = 6'h1a; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (21) step();
    check("flush_pre_busy", {31'd0, a_md_busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_cleared_a", {29'd0, a_md_busy, a_md_start, a_out_valid}, 32'd0);
    #1;
    check("flush_ready_a", {31'd0, a_in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | a_out_valid | a_md_busy | b_out_valid | b_md_busy;
    end
    check("flush_no_late_valid", {31'd0, seen}, 32'd0);

    // Flush together with a request drops the request
    oper = 4'b0000; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, a_in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_drop", {31'd0, a_out_valid}, 32'd0);

    // Reset in the middle of a DIV
    oper = 4'b0010; funct = 6'h1b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_view_a", view_a(), 32'd0);
    check("midreset_ready_a", {31'd0, a_in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("postreset_ready_a", {31'd0, a_in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | a_md_start | a_md_busy | a_out_valid;
    end
    check("postreset_no_md", {31'd0, seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Successor to the combinational ALU control decoder: registered ID/EX decode stage with valid/ready handshake.
- Adds full SLT/SLTU/LUI/MULT/DIV decoding and a multi-cycle mul/div sequencer that stalls upstream for a programmable number of cycles.
- Sits between the main control unit (oper) / instruction funct field and the EX-stage ALU plus mul/div datapath.
- Never emits X; an undecodable funct raises illegal.

Parameters:
- OPER_W, 4, width of main-control oper code.
- ALU_OP_W, 4, width of alu_op output; must be >=4, upper bits zero-filled.
- MUL_CYCLES, 4, EX cycles a MULT/MULTU occupies; range 1..64.
- DIV_CYCLES, 32, EX cycles a DIV/DIVU occupies; range 1..64.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode request present
- in_ready  out  1  request accepted this cycle when in_valid&&in_ready
- oper  in  OPER_W  main-control class code
- funct  in  6  R-type function field
- flush  in  1  synchronous pipeline kill
- out_valid  out  1  alu_op/flags valid to EX
- out_ready  in  1  EX consumes output
- alu_op  out  ALU_OP_W  ALU operation code
- shamt_sel  out  1  1 = shift amount from shamt field, 0 = from rs
- is_unsigned  out  1  unsigned variant (ADDU/ADDIU/SUBU/SLTU/SLTIU/MULTU/DIVU)
- md_start  out  1  one-cycle pulse launching mul/div datapath
- md_busy  out  1  mul/div sequence in progress
- illegal  out  1  unknown oper or R-type funct; qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counter 0. alu_op=0 (ADD).
- alu_op codes:
  - ADD 0, SUB 1, OR 2, NOR 3, AND 4, XOR 6, SLL 7, SRL 8, SRA 9, SLT 10, SLTU 11, LUI 12, MUL 13, DIV 14; 5 and 15 reserved.
- oper decode:
  - 0000 ADD (load/store); 0001 SUB (branch/jump); 0010 R-type, decoded by funct.
  - 1000/1001 ADD (ADDI/ADDIU); 1010 SLT (SLTI); 1011 SLTU (SLTIU).
  - 1100 AND; 1101 OR; 1110 XOR; 1111 LUI (was ADD in the previous generation).
  - Other values: ADD with illegal=1.
- funct decode:
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT; 101011 SLTU.
  - 000000 SLL, 000010 SRL, 000011 SRA (shamt_sel=1); 000100/000110/000111 same ops with shamt_sel=0.
  - 011000/011001 MUL; 011010/011011 DIV.
  - Others: ADD with illegal=1.
- Latency: 1 cycle. Accepted request appears on outputs the next cycle; outputs are registered.
- FSM IDLE:
  - in_ready = !out_valid || out_ready.
  - Accepting a non-MD op: out_valid<=1, decoded fields loaded. Output held stable while out_valid && !out_ready.
  - Output consumed with no new accept: out_valid<=0.
  - Accepting MUL/DIV: go MD_RUN; md_start pulses 1 cycle; md_busy<=1; out_valid<=0; counter <= N-1, where N = MUL_CYCLES or DIV_CYCLES.
- FSM MD_RUN:
  - in_ready=0. Counter decrements each cycle.
  - At counter==0: out_valid<=1 with alu_op MUL/DIV; md_busy<=0; go IDLE.
  - N=1: out_valid rises the cycle after md_start.
- Counter width: $clog2(64)=6. Counter never wraps below 0.
- flush:
  - Next edge clears out_valid, md_busy, md_start and counter; state IDLE.
  - Flush with in_valid the same cycle: request dropped; in_ready forced 0 that cycle.
- Reset asserted mid-MD: immediate return to reset values; no md_start re-issue after release.

Decomposition:
- Package alu_ctrl_pkg holds:
  - alu_op code constants (ALU_ADD..ALU_DIV);
  - oper class constants;
  - funct constants;
  - FSM state encoding (IDLE, MD_RUN).
- One natural sub-module: alu_ctrl_decode, a pure combinational oper/funct -> {alu_op, shamt_sel, is_unsigned, is_md, illegal} function, reused by any future decoder.

Test Plan:
- Reset check: rst_n low mid-stream -> all outputs 0 immediately. Release -> in_ready=1, out_valid=0.
- R-type sweep:
  - oper=0010 with each legal funct, out_ready=1 -> codes per table one cycle later.
  - SLLV gives alu_op=7, shamt_sel=0; SLTU gives alu_op=11, is_unsigned=1.
  - funct=111111 gives alu_op=0, illegal=1.
- I-type: oper=1111 -> alu_op=12. oper=1011 -> alu_op=11, is_unsigned=1. oper=0011 -> illegal=1.
- Backpressure: out_ready=0 for 3 cycles after ADD accept -> outputs stable and in_ready=0. out_ready=1 -> next request accepted the same cycle.
- MD timing:
  - DIVU with DIV_CYCLES=32 -> md_start at cycle 1; md_busy high for 32 cycles.
  - out_valid with alu_op=14, is_unsigned=1 after 32 cycles; in_ready=0 throughout.
  - Repeat with MUL_CYCLES=1.
- Flush during MD_RUN at count 10 -> next cycle md_busy=0, out_valid=0, state IDLE, in_ready=1. No late out_valid.
